// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder for the 8-bit parallel LCD write bus.
// Decodes CASET/PASET/RAMWR/SWRESET/DISPON/DISPOFF and emits one pixel
// event, with its screen coordinates, for each RGB565 byte pair.
module lcd_bus_receiver #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        px_valid,
  output logic [8:0]  px_x,
  output logic [8:0]  px_y,
  output logic [15:0] px_color,
  output logic        frame_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        disp_on,
  output logic        cfg_err
);

  // Range limits kept at full argument width so out-of-range high bytes are caught.
  localparam logic [15:0] WIDTH16  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT16 = 16'(HEIGHT);
  localparam logic [8:0]  EC_RST   = 9'(WIDTH - 1);
  localparam logic [8:0]  EP_RST   = 9'(HEIGHT - 1);

  typedef enum logic [3:0] {
    IDLE, CA0, CA1, CA2, CA3, PA0, PA1, PA2, PA3, WR_HI, WR_LO, SKIP
  } state_t;

  state_t      state, state_next;
  logic        wr_q;
  logic [15:0] arg_start, arg_start_next;
  logic [7:0]  arg_end_hi, arg_end_hi_next;
  logic [8:0]  sc, sc_next, ec, ec_next, sp, sp_next, ep, ep_next;
  logic [8:0]  x, x_next, y, y_next;
  logic [7:0]  hi_byte, hi_byte_next;
  logic        px_valid_next, frame_done_next, cmd_valid_next;
  logic [8:0]  px_x_next, px_y_next;
  logic [15:0] px_color_next;
  logic [7:0]  cmd_byte_next;
  logic        disp_on_next, cfg_err_next;

  logic        stb;
  logic [15:0] arg_end;

  assign stb     = wr & ~wr_q;
  assign arg_end = {arg_end_hi, D};

  // State and datapath registers; async reset drops any partial pixel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      arg_start  <= '0;
      arg_end_hi <= '0;
      sc         <= '0;
      ec         <= EC_RST;
      sp         <= '0;
      ep         <= EP_RST;
      x          <= '0;
      y          <= '0;
      hi_byte    <= '0;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_color   <= '0;
      frame_done <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      disp_on    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_next;
      wr_q       <= wr;
      arg_start  <= arg_start_next;
      arg_end_hi <= arg_end_hi_next;
      sc         <= sc_next;
      ec         <= ec_next;
      sp         <= sp_next;
      ep         <= ep_next;
      x          <= x_next;
      y          <= y_next;
      hi_byte    <= hi_byte_next;
      px_valid   <= px_valid_next;
      px_x       <= px_x_next;
      px_y       <= px_y_next;
      px_color   <= px_color_next;
      frame_done <= frame_done_next;
      cmd_valid  <= cmd_valid_next;
      cmd_byte   <= cmd_byte_next;
      disp_on    <= disp_on_next;
      cfg_err    <= cfg_err_next;
    end
  end

  // Byte decoder: commands always win, data bytes act on the current state.
  always_comb begin
    state_next      = state;
    arg_start_next  = arg_start;
    arg_end_hi_next = arg_end_hi;
    sc_next         = sc;
    ec_next         = ec;
    sp_next         = sp;
    ep_next         = ep;
    x_next          = x;
    y_next          = y;
    hi_byte_next    = hi_byte;
    px_valid_next   = 1'b0;
    px_x_next       = px_x;
    px_y_next       = px_y;
    px_color_next   = px_color;
    frame_done_next = 1'b0;
    cmd_valid_next  = 1'b0;
    cmd_byte_next   = cmd_byte;
    disp_on_next    = disp_on;
    cfg_err_next    = cfg_err;

    if (stb) begin
      if (!dcx) begin
        cmd_valid_next = 1'b1;
        cmd_byte_next  = D;
        case (D)
          8'h2A: state_next = CA0;
          8'h2B: state_next = PA0;
          8'h2C: begin
            state_next = WR_HI;
            x_next     = sc;
            y_next     = sp;
          end
          8'h01: begin
            state_next   = IDLE;
            sc_next      = '0;
            ec_next      = EC_RST;
            sp_next      = '0;
            ep_next      = EP_RST;
            disp_on_next = 1'b0;
            cfg_err_next = 1'b0;
          end
          8'h29: begin
            state_next   = IDLE;
            disp_on_next = 1'b1;
          end
          8'h28: begin
            state_next   = IDLE;
            disp_on_next = 1'b0;
          end
          default: state_next = SKIP;
        endcase
      end else begin
        case (state)
          CA0: begin arg_start_next[15:8] = D; state_next = CA1; end
          CA1: begin arg_start_next[7:0]  = D; state_next = CA2; end
          CA2: begin arg_end_hi_next      = D; state_next = CA3; end
          CA3: begin
            if ((arg_start > arg_end) || (arg_end >= WIDTH16)) begin
              cfg_err_next = 1'b1;
            end else begin
              sc_next = arg_start[8:0];
              ec_next = arg_end[8:0];
            end
            state_next = IDLE;
          end
          PA0: begin arg_start_next[15:8] = D; state_next = PA1; end
          PA1: begin arg_start_next[7:0]  = D; state_next = PA2; end
          PA2: begin arg_end_hi_next      = D; state_next = PA3; end
          PA3: begin
            if ((arg_start > arg_end) || (arg_end >= HEIGHT16)) begin
              cfg_err_next = 1'b1;
            end else begin
              sp_next = arg_start[8:0];
              ep_next = arg_end[8:0];
            end
            state_next = IDLE;
          end
          WR_HI: begin
            hi_byte_next = D;
            state_next   = WR_LO;
          end
          WR_LO: begin
            px_valid_next = 1'b1;
            px_x_next     = x;
            px_y_next     = y;
            px_color_next = {hi_byte, D};
            state_next    = WR_HI;
            // Raster advance inside the window, wrapping to its origin.
            if (x != ec) begin
              x_next = x + 9'd1;
            end else if (y != ep) begin
              x_next = sc;
              y_next = y + 9'd1;
            end else begin
              x_next          = sc;
              y_next          = sp;
              frame_done_next = 1'b1;
            end
          end
          default: state_next = state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed testbench for lcd_bus_receiver.
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        wr = 1'b0;
  logic        dcx = 1'b0;
  logic [7:0]  d_bus = 8'h00;
  logic        px_valid, frame_done, cmd_valid, disp_on, cfg_err;
  logic [8:0]  px_x, px_y;
  logic [15:0] px_color;
  logic [7:0]  cmd_byte;

  int checks = 0;
  int errors = 0;

  lcd_bus_receiver #(.WIDTH(320), .HEIGHT(240)) dut (
    .clk(clk), .nrst(nrst), .wr(wr), .dcx(dcx), .D(d_bus),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .frame_done(frame_done), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .disp_on(disp_on), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One wr pulse; returns at the negedge after the strobe edge, where outputs are valid.
  task automatic send_byte(input logic c, input logic [7:0] d);
    @(negedge clk);
    dcx = c; d_bus = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(1'b0, c);
    chk("cmd_valid", 32'(cmd_valid), 32'd1);
    chk("cmd_byte", 32'(cmd_byte), 32'(c));
  endtask

  task automatic send_args(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    send_byte(1'b1, a); send_byte(1'b1, b); send_byte(1'b1, c); send_byte(1'b1, d);
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                            input int ex, input int ey, input logic efd);
    send_byte(1'b1, hi);
    chk("px_early", 32'(px_valid), 32'd0);
    send_byte(1'b1, lo);
    $display("pixel color=%04h at (%0d,%0d) fd=%0d", {hi, lo}, px_x, px_y, frame_done);
    chk("px_valid", 32'(px_valid), 32'd1);
    chk("px_x", 32'(px_x), 32'(ex));
    chk("px_y", 32'(px_y), 32'(ey));
    chk("px_color", 32'(px_color), 32'({hi, lo}));
    chk("frame_done", 32'(frame_done), 32'(efd));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_px_x", 32'(px_x), 32'd0);
    chk("rst_px_y", 32'(px_y), 32'd0);
    chk("rst_px_color", 32'(px_color), 32'd0);
    chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
    chk("rst_disp_on", 32'(disp_on), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    nrst = 1'b1;

    // First pixel of the default window
    send_cmd(8'h2C);
    @(negedge clk);
    chk("cmd_pulse_once", 32'(cmd_valid), 32'd0);
    send_pixel(8'hF8, 8'h00, 0, 0, 1'b0);
    @(negedge clk);
    chk("px_pulse_once", 32'(px_valid), 32'd0);

    // Small window 2..5 x 1..2, frame_done only on the last cell, then wrap
    send_cmd(8'h2A); send_args(8'h00, 8'h02, 8'h00, 8'h05);
    send_cmd(8'h2B); send_args(8'h00, 8'h01, 8'h00, 8'h02);
    chk("cfg_err_ok", 32'(cfg_err), 32'd0);
    send_cmd(8'h2C);
    for (int i = 0; i < 8; i++)
      send_pixel(8'(i), 8'(8'h10 + i), 2 + (i % 4), 1 + (i / 4), i == 7);
    send_pixel(8'hAA, 8'h55, 2, 1, 1'b0);

    // Rejected window keeps the old one; SWRESET clears cfg_err
    send_cmd(8'h2A); send_args(8'h00, 8'h0A, 8'h00, 8'h05);
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    send_cmd(8'h2C);
    send_pixel(8'h01, 8'h02, 2, 1, 1'b0);
    send_cmd(8'h01);
    chk("cfg_err_clr", 32'(cfg_err), 32'd0);
    // EC = 0x0140 is one past the last column
    send_cmd(8'h2A); send_args(8'h00, 8'h00, 8'h01, 8'h40);
    chk("cfg_err_ec320", 32'(cfg_err), 32'd1);
    send_cmd(8'h2C);
    send_pixel(8'h03, 8'h04, 0, 0, 1'b0);
    send_cmd(8'h01);
    chk("cfg_err_clr2", 32'(cfg_err), 32'd0);
    // EP = 0x00F0 is one past the last row
    send_cmd(8'h2B); send_args(8'h00, 8'h00, 8'h00, 8'hF0);
    chk("cfg_err_ep240", 32'(cfg_err), 32'd1);
    send_cmd(8'h01);

    // Command aborts a half pixel; DISPON/DISPOFF; data ignored afterwards
    send_cmd(8'h2C);
    send_byte(1'b1, 8'h12);
    send_cmd(8'h29);
    chk("abort_no_px", 32'(px_valid), 32'd0);
    chk("disp_on_set", 32'(disp_on), 32'd1);
    send_byte(1'b1, 8'h34);
    chk("idle_data1", 32'(px_valid), 32'd0);
    send_byte(1'b1, 8'h56);
    chk("idle_data2", 32'(px_valid), 32'd0);
    send_cmd(8'h55);
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'h02);
    chk("skip_data", 32'(px_valid), 32'd0);
    send_cmd(8'h28);
    chk("disp_on_clr", 32'(disp_on), 32'd0);

    // wr held high for 5 cycles takes exactly one byte
    send_cmd(8'h2C);
    @(negedge clk);
    dcx = 1'b1; d_bus = 8'hAB; wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_no_px", 32'(px_valid), 32'd0);
    end
    wr = 1'b0;
    send_byte(1'b1, 8'hCD);
    chk("hold_px_valid", 32'(px_valid), 32'd1);
    chk("hold_px_color", 32'(px_color), 32'hABCD);
    chk("hold_px_x", 32'(px_x), 32'd0);

    // Reset between hi and lo drops the pixel
    send_byte(1'b1, 8'h11);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    nrst = 1'b1;
    send_byte(1'b1, 8'h22);
    chk("post_rst_no_px", 32'(px_valid), 32'd0);

    // Full-width window on the last two rows: frame_done only at (319,239)
    send_cmd(8'h2A); send_args(8'h00, 8'h00, 8'h01, 8'h3F);
    send_cmd(8'h2B); send_args(8'h00, 8'hEE, 8'h00, 8'hEF);
    chk("cfg_err_full", 32'(cfg_err), 32'd0);
    send_cmd(8'h2C);
    for (int i = 0; i < 640; i++)
      send_pixel(8'(i >> 8), 8'(i), i % 320, 238 + i / 320, i == 639);
    send_pixel(8'h77, 8'h88, 0, 238, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
